// File: rtl/stream_arbiter_wrr.sv
// N-to-1 valid/ready stream arbiter (prio, round-robin or weighted round-robin), 0 or 1 cycle latency.
// Backpressure: oup_ready_i gates the granted input directly, or via a one-entry output slice.
module stream_arbiter_wrr #(
    parameter int    N_INP        = 4,
    parameter int    DATA_WIDTH   = 32,
    parameter int    WEIGHT_WIDTH = 4,
    parameter string ARBITER      = "wrr",
    parameter int    OUT_REG      = 0,
    localparam int   IDX_W        = (N_INP > 1) ? $clog2(N_INP) : 1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          flush_i,
    input  logic [N_INP*WEIGHT_WIDTH-1:0] weight_i,
    input  logic [N_INP*DATA_WIDTH-1:0]   inp_data_i,
    input  logic [N_INP-1:0]              inp_valid_i,
    output logic [N_INP-1:0]              inp_ready_o,
    output logic [DATA_WIDTH-1:0]         oup_data_o,
    output logic                          oup_valid_o,
    input  logic                          oup_ready_i,
    output logic [IDX_W-1:0]              oup_idx_o
);

    if (N_INP < 2 || N_INP > 32) begin : g_bad_n
        $fatal(1, "stream_arbiter_wrr: N_INP must be in 2..32");
    end
    if (ARBITER != "rr" && ARBITER != "prio" && ARBITER != "wrr") begin : g_bad_arb
        $fatal(1, "stream_arbiter_wrr: ARBITER must be rr, prio or wrr");
    end

    localparam bit PRIO = (ARBITER == "prio");
    localparam bit RR   = (ARBITER == "rr");

    logic [WEIGHT_WIDTH-1:0] weight_a [N_INP];
    logic [DATA_WIDTH-1:0]   data_a   [N_INP];

    logic [IDX_W-1:0]        ptr_q;
    logic [WEIGHT_WIDTH-1:0] cnt_q;
    logic                    lock_vld_q;
    logic [IDX_W-1:0]        lock_idx_q;

    logic                    any_vld;
    logic                    live;
    logic                    in_acc;
    logic                    in_hs;
    logic [IDX_W-1:0]        base;
    logic [IDX_W:0]          cand;
    logic                    arb_hit;
    logic [IDX_W-1:0]        arb_idx;
    logic [IDX_W-1:0]        sel;
    logic [IDX_W-1:0]        ptr_nxt;
    logic [WEIGHT_WIDTH:0]   w_ptr;
    logic [WEIGHT_WIDTH:0]   cnt_inc;

    for (genvar gi = 0; gi < N_INP; gi++) begin : g_unpack
        assign weight_a[gi]    = weight_i[gi*WEIGHT_WIDTH +: WEIGHT_WIDTH];
        assign data_a[gi]      = inp_data_i[gi*DATA_WIDTH +: DATA_WIDTH];
        assign inp_ready_o[gi] = live & in_acc & (sel == IDX_W'(gi));
    end

    assign any_vld = |inp_valid_i;
    assign live    = ~rst_i & ~flush_i & any_vld;
    assign in_hs   = |(inp_valid_i & inp_ready_o);
    assign base    = PRIO ? '0 : ptr_q;

    // Cyclic search starting at base; prio mode simply starts at index 0.
    always_comb begin
        arb_idx = '0;
        arb_hit = 1'b0;
        cand    = '0;
        for (int k = 0; k < N_INP; k++) begin
            cand = {1'b0, base} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(N_INP)) cand = cand - (IDX_W+1)'(N_INP);
            if (!arb_hit && inp_valid_i[cand[IDX_W-1:0]]) begin
                arb_hit = 1'b1;
                arb_idx = cand[IDX_W-1:0];
            end
        end
    end

    assign sel     = lock_vld_q ? lock_idx_q : arb_idx;
    assign ptr_nxt = (sel == IDX_W'(N_INP - 1)) ? '0 : sel + IDX_W'(1);
    assign w_ptr   = (RR || weight_a[ptr_q] == '0) ? {{WEIGHT_WIDTH{1'b0}}, 1'b1}
                                                   : {1'b0, weight_a[ptr_q]};
    assign cnt_inc = {1'b0, cnt_q} + {{WEIGHT_WIDTH{1'b0}}, 1'b1};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q      <= '0;
            cnt_q      <= '0;
            lock_vld_q <= 1'b0;
            lock_idx_q <= '0;
        end else if (flush_i) begin
            ptr_q      <= '0;
            cnt_q      <= '0;
            lock_vld_q <= 1'b0;
            lock_idx_q <= '0;
        end else if (in_hs) begin
            lock_vld_q <= 1'b0;
            if (sel == ptr_q && cnt_inc < w_ptr) begin
                cnt_q <= cnt_inc[WEIGHT_WIDTH-1:0];
            end else begin
                ptr_q <= ptr_nxt;
                cnt_q <= '0;
            end
        end else if (any_vld) begin
            // Hold the presented choice so a late higher-priority request cannot steal it.
            lock_vld_q <= 1'b1;
            lock_idx_q <= sel;
        end
    end

    if (OUT_REG == 0) begin : g_comb
        assign in_acc      = oup_ready_i;
        assign oup_valid_o = live;
        assign oup_data_o  = live ? data_a[sel] : '0;
        assign oup_idx_o   = live ? sel : '0;
    end else begin : g_reg
        logic                  full_q;
        logic [DATA_WIDTH-1:0] data_q;
        logic [IDX_W-1:0]      idx_q;

        assign in_acc      = ~full_q | oup_ready_i;
        assign oup_valid_o = full_q & ~flush_i;
        assign oup_data_o  = data_q;
        assign oup_idx_o   = idx_q;

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                full_q <= 1'b0;
                data_q <= '0;
                idx_q  <= '0;
            end else if (flush_i) begin
                full_q <= 1'b0;
            end else if (in_hs) begin
                full_q <= 1'b1;
                data_q <= data_a[sel];
                idx_q  <= sel;
            end else if (oup_ready_i) begin
                full_q <= 1'b0;
            end
        end
    end

    a_lock_stable: assert property (@(posedge clk_i) disable iff (rst_i || flush_i)
        lock_vld_q |-> inp_valid_i[lock_idx_q])
        else $error("stream_arbiter_wrr: locked input %0d dropped valid", lock_idx_q);

endmodule

// File: doc/stream_arbiter_wrr.md
STREAM_ARBITER_WRR -- requirements
Module: stream_arbiter_wrr

Interface
REQ-001 SHALL have parameter N_INP, default 4: number of input streams, legal range 2..32.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: payload bits per stream.
REQ-003 SHALL have parameter WEIGHT_WIDTH, default 4: bits per runtime weight.
REQ-004 SHALL have parameter ARBITER, default "wrr": "rr", "prio" or "wrr"; any other value is an elaboration-time fatal error.
REQ-005 SHALL have parameter OUT_REG, default 0: 0 gives a combinational output path, 1 gives a one-entry registered output slice.
REQ-006 SHALL derive IDX_W = max(1, clog2(N_INP)).
REQ-007 clk_i  in  1  clock; all state changes on rising edge.
REQ-008 rst_i  in  1  reset, asynchronous, active-high.
REQ-009 flush_i  in  1  synchronous clear of all arbitration and buffer state.
REQ-010 weight_i  in  N_INP*WEIGHT_WIDTH  per-input weight, slice i at [i*WEIGHT_WIDTH +: WEIGHT_WIDTH]; sampled every cycle.
REQ-011 inp_data_i  in  N_INP*DATA_WIDTH  input payloads, slice i at [i*DATA_WIDTH +: DATA_WIDTH].
REQ-012 inp_valid_i  in  N_INP  input valid per stream.
REQ-013 inp_ready_o  out  N_INP  input ready per stream; one-hot or zero.
REQ-014 oup_data_o  out  DATA_WIDTH  output payload.
REQ-015 oup_valid_o  out  1  output valid.
REQ-016 oup_ready_i  in  1  output ready.
REQ-017 oup_idx_o  out  IDX_W  index of the input that supplies oup_data_o.

Function
REQ-018 Input handshake i SHALL occur when inp_valid_i[i] & inp_ready_o[i]; output handshake SHALL occur when oup_valid_o & oup_ready_i.
REQ-019 Effective weight w(i) SHALL be weight_i slice i, with 0 treated as 1.
REQ-020 In "prio" mode, selection SHALL be the lowest-index valid input.
REQ-021 In "rr" and "wrr" modes, selection SHALL be the first valid index at or after pointer ptr, searching cyclically; "rr" behaves as "wrr" with every w(i)=1.
REQ-022 State SHALL be ptr (IDX_W bits) and cnt (WEIGHT_WIDTH bits).
REQ-023 On an input handshake from index g: if g==ptr and cnt+1 < w(ptr), then cnt <= cnt+1 and ptr is unchanged; otherwise ptr <= (g+1) mod N_INP and cnt <= 0.
REQ-024 Pointer wrap SHALL go from N_INP-1 to 0, including for non-power-of-two N_INP.
REQ-025 Lock-in: once a selection is presented without a handshake, the selected index SHALL be held in a lock register until that handshake, ignoring new requests of higher priority.
REQ-026 Input valids are assumed stable until handshake (AXI rule); a locked input dropping valid is a protocol violation and SHALL be flagged by an assertion.
REQ-027 OUT_REG=0: oup_valid_o = |inp_valid_i; oup_data_o and oup_idx_o come from the selected input; inp_ready_o[sel] = oup_ready_i; latency 0.
REQ-028 OUT_REG=1: the slice SHALL accept when empty or drained in the same cycle (inp_ready_o[sel] = ~full | oup_ready_i), giving 1-cycle latency and full throughput.
REQ-029 OUT_REG=1: oup_data_o and oup_idx_o SHALL stay stable while oup_valid_o=1 and oup_ready_i=0.
REQ-030 OUT_REG=1: arbitration SHALL take effect at the input handshake; lock-in applies to the input side.
REQ-031 With no valid input, inp_ready_o SHALL be 0; in OUT_REG=0 mode oup_idx_o and oup_data_o SHALL be 0.
REQ-032 flush_i=1 SHALL force inp_ready_o=0 and oup_valid_o=0 that cycle, and at the edge set ptr=0, cnt=0, clear the lock and empty the slice; buffered data is discarded.
REQ-033 flush_i SHALL take priority over a simultaneous handshake; no state update from that handshake occurs.
REQ-034 A weight change SHALL take effect at the next REQ-023 comparison; if cnt >= the new w(ptr), the next ptr handshake SHALL advance ptr.

Reset
REQ-035 While rst_i=1: ptr=0, cnt=0, lock clear, slice empty, oup_valid_o=0, inp_ready_o=0, oup_data_o=0, oup_idx_o=0.
REQ-036 Assertion of rst_i mid-transfer SHALL discard all state immediately (asynchronous); operation SHALL resume on the first edge after release, with ptr=0.

Verification
REQ-037 N=4, wrr, weights {3,1,1,1}, all valid, oup_ready_i=1 -> grant sequence 0,0,0,1,2,3,0,0,0,...
REQ-038 rr mode, valids 4'b1010, ready=1 -> grants 1,3,1,3; ptr wraps from 3 to 0.
REQ-039 OUT_REG=0, input 2 selected and ready=0 for 5 cycles, input 0 then asserts -> oup_idx_o stays 2 and data stays stable until the handshake; input 0 is granted next.
REQ-040 OUT_REG=1, all valid, ready toggling 1010 -> no data lost or duplicated; throughput 1/cycle while ready=1; latency 1.
REQ-041 wrr with cnt=2 on input 0, flush_i pulse together with a handshake -> that cycle oup_valid_o=0 and inp_ready_o=0; next grant is index 0 with cnt restarting from 0.
REQ-042 N=3 (non-power-of-two), weight 0 on all inputs -> plain round robin 0,1,2,0; rst_i asserted mid-stream -> outputs go to zero asynchronously.
